// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART byte receiver: SYNC, LEN, payload, CSUM.
// Buffers the payload and exposes it to the command logic once the checksum passes.
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned TIMEOUT   = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iValid,
  input  logic [7:0]        iData,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [7:0]        oRdData,
  output logic              oFrameValid,
  output logic [ADDR_W:0]   oLen,
  input  logic              iAck,
  output logic [7:0]        oErrCnt
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_HOLD
  } state_t;

  state_t           state;
  logic             v_d;
  logic [7:0]       sum;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic [7:0]       mem [DEPTH];

  logic strobe;
  logic in_frame;
  logic tmo_hit;
  logic wr_en;
  logic len_bad;
  logic is_sync;

  // One strobe per received byte, independent of how long iValid is stretched.
  assign strobe   = iValid & ~v_d;
  assign is_sync  = (iData == SYNC_BYTE);
  assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
  assign tmo_hit  = in_frame && !strobe && (tmo == TMO_W'(TIMEOUT - 1));
  assign wr_en    = rst && strobe && (state == S_PAYLOAD);
  assign len_bad  = (iData == 8'h00) || (iData > 8'(MAX_LEN));

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      v_d         <= 1'b0;
      sum         <= 8'h00;
      len         <= '0;
      cnt         <= '0;
      tmo         <= '0;
      oFrameValid <= 1'b0;
      oLen        <= '0;
      oErrCnt     <= 8'h00;
      oRdData     <= 8'h00;
    end else begin
      v_d     <= iValid;
      oRdData <= (LEN_W'(iRdAddr) < LEN_W'(MAX_LEN)) ? mem[iRdAddr] : 8'h00;

      // Inter-byte watchdog only runs while a frame is being assembled.
      if (in_frame && !strobe) begin
        tmo <= tmo + TMO_W'(1);
      end else begin
        tmo <= '0;
      end

      case (state)
        S_IDLE: begin
          if (strobe && is_sync) begin
            state <= S_LEN;
          end
        end

        S_LEN: begin
          if (strobe) begin
            sum <= iData;
            cnt <= '0;
            if (len_bad) begin
              state   <= S_IDLE;
              oErrCnt <= sat_inc(oErrCnt);
            end else begin
              len   <= LEN_W'(iData);
              state <= S_PAYLOAD;
            end
          end else if (tmo_hit) begin
            state   <= S_IDLE;
            oErrCnt <= sat_inc(oErrCnt);
          end
        end

        S_PAYLOAD: begin
          if (strobe) begin
            sum <= sum + iData;
            cnt <= cnt + LEN_W'(1);
            if (cnt + LEN_W'(1) == len) begin
              state <= S_CSUM;
            end
          end else if (tmo_hit) begin
            state   <= S_IDLE;
            oErrCnt <= sat_inc(oErrCnt);
          end
        end

        S_CSUM: begin
          if (strobe) begin
            if (iData == sum) begin
              state       <= S_HOLD;
              oFrameValid <= 1'b1;
              oLen        <= len;
            end else begin
              state   <= S_IDLE;
              oErrCnt <= sat_inc(oErrCnt);
            end
          end else if (tmo_hit) begin
            state   <= S_IDLE;
            oErrCnt <= sat_inc(oErrCnt);
          end
        end

        S_HOLD: begin
          // Ack beats a colliding byte; that byte is then treated as if seen in IDLE.
          if (iAck) begin
            oFrameValid <= 1'b0;
            state       <= (strobe && is_sync) ? S_LEN : S_IDLE;
          end else if (strobe) begin
            oErrCnt <= sat_inc(oErrCnt);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Payload buffer, deliberately not reset; frozen outside PAYLOAD.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt[ADDR_W-1:0]] <= iData;
    end
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART byte receiver and consumes its stretched byte strobe (oValid/oData).
- Parses byte frames of the form SYNC, LEN, LEN payload bytes, CSUM, and buffers the payload internally.
- Releases a frame to the command logic only after the checksum passes.
- Counts framing, checksum and timeout errors for diagnostics.

Parameters:
SYNC_BYTE  8'hA5  frame start marker
MAX_LEN  16  maximum payload bytes per frame (1..2^ADDR_W)
ADDR_W  4  payload buffer address width
TIMEOUT  2000  max clk cycles between consecutive byte strobes inside a frame (~12 byte times at 16x oversampling)

Ports:
clk  in  1  system clock (same domain as UART receiver)
rst  in  1  synchronous reset, active-low
iValid  in  1  byte valid from receiver; high for several consecutive cycles per byte
iData  in  8  received byte, stable while iValid high
iRdAddr  in  ADDR_W  payload buffer read address
oRdData  out  8  payload byte at iRdAddr, registered
oFrameValid  out  1  good frame held in buffer, level
oLen  out  ADDR_W+1  payload length of held frame
iAck  in  1  consumer done with frame; clears oFrameValid
oErrCnt  out  8  saturating error counter

Behaviour:
- Reset and clock: reset is rst, synchronous, active-low; clock is clk. While rst=0:
  - oFrameValid=0, oLen=0, oErrCnt=0, oRdData=0.
  - State is IDLE; internal checksum and timeout counter are 0.
  - Buffer contents are not reset.
- Byte strobe:
  - iValid is registered into vD. strobe = iValid & ~vD.
  - Exactly one strobe per receiver byte regardless of how long iValid stays high. iData is sampled on the strobe cycle.
- Checksum: 8-bit running sum, mod 256, of the LEN byte and all payload bytes. Frame is good if CSUM byte == sum.
- States:
  - IDLE:
    - strobe with iData==SYNC_BYTE -> LEN.
    - Any other byte is discarded silently, with no error count.
  - LEN: on strobe, sum <= iData, cnt <= 0.
    - If iData==0 or iData>MAX_LEN -> IDLE, error++.
    - Otherwise latch length and go to PAYLOAD.
  - PAYLOAD: on strobe, buf[cnt] <= iData, sum += iData, cnt++.
    - After byte number LEN -> CSUM.
  - CSUM: on strobe:
    - Match -> HOLD, oFrameValid<=1, oLen<=LEN. oFrameValid rises the cycle after the strobe.
    - Mismatch -> IDLE, error++.
  - HOLD: oFrameValid=1 and the buffer is frozen.
    - Strobes are dropped, error++ per dropped byte.
    - iAck=1 -> oFrameValid<=0, state IDLE.
- Timeout:
  - A cycle counter runs in LEN, PAYLOAD and CSUM and clears on every strobe.
  - Reaching TIMEOUT-1 with no strobe -> IDLE, error++. The partial frame is discarded.
  - The counter is held at 0 in IDLE and HOLD.
- Simultaneous events:
  - iAck and strobe in the same cycle while in HOLD: ack wins, no error is counted. The byte is evaluated as in IDLE, so SYNC_BYTE goes directly to LEN.
  - Timeout and strobe in the same cycle: the strobe wins and the counter clears.
  - iAck outside HOLD is ignored.
- Error counter:
  - oErrCnt saturates at 8'hFF, no wrap.
  - Multiple error sources are mutually exclusive per cycle, so the increment is at most +1 per cycle.
- Read port:
  - oRdData <= buf[iRdAddr] every cycle, 1-cycle latency.
  - Contents are valid for addresses < oLen while oFrameValid=1.
  - Reads at addresses >= MAX_LEN return 0.
- Reset mid-frame: abandons the frame and returns to IDLE. The next accepted frame must begin with a fresh SYNC_BYTE. Reset also clears vD, so if iValid is already high, the first post-reset cycle generates a strobe.
- Sizing: LEN compare uses ADDR_W+1 bits, so MAX_LEN=2^ADDR_W is legal.

Test Plan:
- Good frame: bytes A5 03 11 22 33 69, each iValid held 4 cycles, 160-cycle spacing -> oFrameValid=1 one cycle after the 0x69 strobe; oLen=3; reads at addr 0/1/2 return 11/22/33 one cycle later; oErrCnt=0; iAck -> oFrameValid=0 next cycle.
- Bad checksum: A5 03 11 22 33 6A -> oFrameValid stays 0, oErrCnt=1; a following good frame is accepted normally.
- Garbage and length errors: 00 FF 5A, then A5 00, then A5 11 (17 > MAX_LEN) -> no frame, oErrCnt=2 (garbage not counted), state IDLE.
- Timeout: A5 02 44, then no byte for 2000 cycles, then 55 66 -> no frame, oErrCnt=1; the later bytes are ignored as non-sync.
- HOLD overrun and ack collision: with a good frame held, send 3 bytes -> oErrCnt=3 and buffer unchanged; then assert iAck in the same cycle as an A5 strobe followed by 01 7E 7F -> new frame valid, oLen=1, buf[0]=7E, no additional error.
- Reset mid-frame and saturation: rst=0 after A5 04 01 -> all outputs 0; then 300 bad-checksum frames -> oErrCnt=FF, held.
